// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared RV32I pipeline constants and fetch-stage types
//
// Purpose : constants and enumerations shared by the fetch stage and its PC generator.
// Contents: PC_RESET, NOP_INSN, fetch FSM state encoding, PC-source and IF/ID-update selects.

package riscv_defs;

  // PC loaded on reset; equals the imemory base address.
  localparam logic [31:0] PC_RESET = 32'h0100_0000;

  // addi x0,x0,0 used as a pipeline bubble.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  // Next-PC source selected by the fetch FSM.
  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INCR   = 2'd1,
    PC_TARGET = 2'd2
  } pc_sel_e;

  // What the IF/ID register does on the coming edge.
  typedef enum logic [1:0] {
    FD_HOLD   = 2'd0,
    FD_LOAD   = 2'd1,
    FD_BUBBLE = 2'd2
  } fd_op_e;

  // Instructions are word aligned: drop the two low bits of a jump target.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - program counter register and next-PC selection
//
// Purpose : holds the fetch PC; chooses hold, pc+4 (wrapping modulo 2^32) or an
//           aligned redirect target on each clock edge.
// Ports   :
//   clock    in   1   clock, state updates on posedge
//   reset_n  in   1   asynchronous active-low reset, loads PC_RESET
//   sel      in   2   next-PC source (pc_sel_e)
//   target   in   32  redirect target, low two bits ignored
//   pc       out  32  current program counter

import riscv_defs::*;

module fetch_pc_gen (
  input  logic        clock,
  input  logic        reset_n,
  input  pc_sel_e     sel,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  always_comb begin
    pc_next = pc;
    case (sel)
      PC_INCR:   pc_next = pc + 32'd4;
      PC_TARGET: pc_next = align_word(target);
      default:   pc_next = pc;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= PC_RESET;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage with IF/ID pipeline register
//
// Purpose : owns the fetch FSM (BOOT/RUN/HALT), drives the combinational imemory read,
//           and captures {pc, instruction} into IF/ID, honouring redirect > stall > normal.
// Config  : FETCH_PERF_CNT_EN defined enables the fetch/bubble performance counters;
//           otherwise both counter ports are tied to zero.
// Ports   :
//   clock            in   1   clock, state updates on posedge
//   reset_n          in   1   asynchronous active-low reset
//   stall            in   1   hold PC and IF/ID
//   redirect         in   1   taken branch/jump, flush IF/ID
//   redirect_target  in   32  new PC when redirect=1
//   halt_req         in   1   stop fetching, sticky until reset
//   imem_address     out  32  current PC
//   imem_read_write  out  1   always 0 (read only)
//   imem_data_in     out  32  always 0
//   imem_data_out    in   32  instruction at imem_address, same cycle
//   fd_pc            out  32  IF/ID PC
//   fd_insn          out  32  IF/ID instruction
//   fd_valid         out  1   IF/ID holds a real instruction
//   halted           out  1   FSM is in HALT
//   perf_fetch_cnt   out  32  valid instructions delivered
//   perf_bubble_cnt  out  32  bubbles inserted

import riscv_defs::*;

module fetch_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic [31:0] imem_address,
  output logic        imem_read_write,
  output logic [31:0] imem_data_in,
  input  logic [31:0] imem_data_out,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_insn,
  output logic        fd_valid,
  output logic        halted,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
);

  fetch_state_e state;
  fetch_state_e state_next;
  pc_sel_e      pc_sel;
  fd_op_e       fd_op;
  logic [31:0]  pc;

  fetch_pc_gen u_pc_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .sel     (pc_sel),
    .target  (redirect_target),
    .pc      (pc)
  );

  assign imem_address    = pc;
  assign imem_read_write = 1'b0;
  assign imem_data_in    = 32'd0;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= FS_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      FS_BOOT: state_next = FS_RUN;
      FS_RUN:  if (halt_req) state_next = FS_HALT;
      FS_HALT: state_next = FS_HALT;
      default: state_next = FS_HALT;
    endcase
  end

  // FSM outputs. A halt request kills the fetch in flight (IF/ID gets a bubble and
  // pc stays put), except that a simultaneous redirect still loads its target.
  always_comb begin
    pc_sel = PC_HOLD;
    fd_op  = FD_HOLD;
    halted = 1'b0;
    case (state)
      FS_BOOT: begin
        fd_op = FD_BUBBLE;
      end
      FS_RUN: begin
        if (halt_req) begin
          fd_op = FD_BUBBLE;
          if (redirect) pc_sel = PC_TARGET;
        end else if (redirect) begin
          pc_sel = PC_TARGET;
          fd_op  = FD_BUBBLE;
        end else if (!stall) begin
          pc_sel = PC_INCR;
          fd_op  = FD_LOAD;
        end
      end
      FS_HALT: begin
        fd_op  = FD_BUBBLE;
        halted = 1'b1;
      end
      default: begin
        fd_op = FD_BUBBLE;
      end
    endcase
  end

  // IF/ID register; a bubble leaves fd_pc at its last value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fd_pc    <= 32'd0;
      fd_insn  <= NOP_INSN;
      fd_valid <= 1'b0;
    end else begin
      case (fd_op)
        FD_LOAD: begin
          fd_pc    <= pc;
          fd_insn  <= imem_data_out;
          fd_valid <= 1'b1;
        end
        FD_BUBBLE: begin
          fd_insn  <= NOP_INSN;
          fd_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (fd_op == FD_LOAD)   fetch_cnt  <= fetch_cnt + 32'd1;
      if (fd_op == FD_BUBBLE) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt;
  assign perf_bubble_cnt = bubble_cnt;
`else
  assign perf_fetch_cnt  = 32'd0;
  assign perf_bubble_cnt = 32'd0;
`endif

endmodule
